jk_reg_bank: RTL

- Parametrised bank of WIDTH edge-triggered, clock-qualified storage bits. Each bit behaves as a JK flip-flop, or as SR, T or D under a global mode select.
- Adds a synchronous parallel load, a per-bit change strobe, a saturating activity counter and a sticky SR-illegal flag.
- Used as the general-purpose state-holding primitive for control registers and small sequencers in the design.

---
 rtl/jk_reg_bank.sv | 78 +++++++
 1 files changed

// File: rtl/jk_reg_bank.sv
// Bank of WIDTH storage bits; each bit acts as a JK, SR, T or D flip-flop, selected by mode for all bits.
// Latency: one cycle from input to q; toggled and change_cnt line up with the new q.
// Backpressure: none; en gates updates, load always acts, rst overrides both.
module jk_reg_bank #(
    parameter int                WIDTH   = 8,
    parameter logic [WIDTH-1:0]  RST_VAL = {WIDTH{1'b0}},
    parameter int                CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [1:0]        mode,
    input  logic [WIDTH-1:0]  j,
    input  logic [WIDTH-1:0]  k,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_data,
    input  logic              err_clr,
    output logic [WIDTH-1:0]  q,
    output logic [WIDTH-1:0]  qn,
    output logic [WIDTH-1:0]  toggled,
    output logic [CNT_W-1:0]  change_cnt,
    output logic              sr_err
);

    typedef enum logic [1:0] {
        MODE_JK = 2'b00,
        MODE_SR = 2'b01,
        MODE_T  = 2'b10,
        MODE_D  = 2'b11
    } mode_t;

    logic [WIDTH-1:0] q_next;
    logic             sr_hit;

    always_comb begin
        q_next = q;
        sr_hit = 1'b0;
        if (load) begin
            q_next = load_data;
        end else if (en) begin
            case (mode_t'(mode))
                MODE_JK: q_next = (j & ~q) | (~k & q);
                // S=R=1 falls into the hold term and raises the sticky error.
                MODE_SR: begin
                    q_next = (j & ~k) | (q & ~(j ^ k));
                    sr_hit = |(j & k);
                end
                MODE_T:  q_next = q ^ j;
                MODE_D:  q_next = j;
                default: q_next = q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q          <= RST_VAL;
            toggled    <= '0;
            change_cnt <= '0;
            sr_err     <= 1'b0;
        end else begin
            q       <= q_next;
            toggled <= q_next ^ q;
            if ((q_next != q) && (change_cnt != {CNT_W{1'b1}})) begin
                change_cnt <= change_cnt + 1'b1;
            end
            // A fresh illegal combination beats a simultaneous clear.
            if (sr_hit) begin
                sr_err <= 1'b1;
            end else if (err_clr) begin
                sr_err <= 1'b0;
            end
        end
    end

    assign qn = ~q;

endmodule
